ap3216c_seq: RTL and testbench

Sequencer for the AP3216C ambient-light sensor. It drives a byte-level I2C master through a request/done handshake. After reset it soft-resets and configures the sensor, then reads the ALS low/high data registers periodically. It publishes a coherent 16-bit `als_data` word (the value the display path consumes as `als_kk`) with a one-cycle valid strobe, and handles NACK errors by re-initialising the sensor.

---
 rtl/ap3216c_seq_if.sv | 22 ++
 rtl/ap3216c_seq.sv | 161 ++++++++++++++++
 tb/tb_ap3216c_seq.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ap3216c_seq_if.sv
// Byte-level I2C master handshake used by the AP3216C sequencer.
// The sequencer takes the master modport; the I2C engine (or a bench model) takes slave.
interface ap3216c_seq_if;
    logic       i2c_req;
    logic       i2c_rw;
    logic [6:0] i2c_dev;
    logic [7:0] i2c_reg;
    logic [7:0] i2c_wdata;
    logic       i2c_done;
    logic       i2c_nack;
    logic [7:0] i2c_rdata;

    modport master (
        output i2c_req, i2c_rw, i2c_dev, i2c_reg, i2c_wdata,
        input  i2c_done, i2c_nack, i2c_rdata
    );

    modport slave (
        input  i2c_req, i2c_rw, i2c_dev, i2c_reg, i2c_wdata,
        output i2c_done, i2c_nack, i2c_rdata
    );
endinterface

// File: rtl/ap3216c_seq.sv
// AP3216C ambient-light sequencer: soft-reset, configure, then poll the ALS
// data registers and publish a coherent 16-bit reading; re-initialises on NACK.
module ap3216c_seq #(
    parameter logic [6:0]  DEV_ADDR    = 7'h1E,
    parameter logic [7:0]  CFG_MODE    = 8'h01,
    parameter logic [23:0] RST_WAIT    = 24'd500_000,
    parameter logic [23:0] CFG_WAIT    = 24'd6_000_000,
    parameter logic [23:0] POLL_CYCLES = 24'd5_000_000,
    parameter logic [23:0] ERR_WAIT    = 24'd500_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               force_rd,
    ap3216c_seq_if.master      i2c,
    output logic [15:0]        als_data,
    output logic               als_valid,
    output logic               err,
    output logic [7:0]         err_cnt,
    output logic               ready
);
    localparam int unsigned CNT_W = 24;

    localparam logic [7:0] REG_SYS    = 8'h00;
    localparam logic [7:0] SYS_SWRST  = 8'h04;
    localparam logic [7:0] REG_ALS_LO = 8'h0C;
    localparam logic [7:0] REG_ALS_HI = 8'h0D;

    typedef enum logic [2:0] {
        RST_WR, RST_DLY, CFG_WR, CFG_DLY, RD_LO, RD_HI, POLL_DLY, ERR_DLY
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               req_q, req_d;
    logic               rw_q, rw_d;
    logic [7:0]         reg_q, reg_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [7:0]         lo_tmp, lo_tmp_d;
    logic [15:0]        als_data_d;
    logic               als_valid_d;
    logic               err_d;
    logic [7:0]         err_cnt_d;
    logic               ready_d;

    assign i2c.i2c_req   = req_q;
    assign i2c.i2c_rw    = rw_q;
    assign i2c.i2c_dev   = DEV_ADDR;
    assign i2c.i2c_reg   = reg_q;
    assign i2c.i2c_wdata = wdata_q;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST_WR;
            cnt       <= '0;
            req_q     <= 1'b0;
            rw_q      <= 1'b0;
            reg_q     <= REG_SYS;
            wdata_q   <= SYS_SWRST;
            lo_tmp    <= '0;
            als_data  <= '0;
            als_valid <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
            ready     <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            req_q     <= req_d;
            rw_q      <= rw_d;
            reg_q     <= reg_d;
            wdata_q   <= wdata_d;
            lo_tmp    <= lo_tmp_d;
            als_data  <= als_data_d;
            als_valid <= als_valid_d;
            err       <= err_d;
            err_cnt   <= err_cnt_d;
            ready     <= ready_d;
        end
    end

    // Next-state, request handshake and result capture
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        req_d       = req_q;
        rw_d        = rw_q;
        reg_d       = reg_q;
        wdata_d     = wdata_q;
        lo_tmp_d    = lo_tmp;
        als_data_d  = als_data;
        als_valid_d = 1'b0;
        err_d       = err;
        err_cnt_d   = err_cnt;
        ready_d     = ready;

        case (state)
            RST_WR, CFG_WR, RD_LO, RD_HI: begin
                if (!req_q) begin
                    req_d = en;
                end else if (i2c.i2c_done) begin
                    req_d = 1'b0;
                    if (i2c.i2c_nack) begin
                        err_d     = 1'b1;
                        err_cnt_d = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
                        ready_d   = 1'b0;
                        lo_tmp_d  = '0;
                        state_d   = ERR_DLY;
                        cnt_d     = ERR_WAIT - 24'd1;
                    end else begin
                        case (state)
                            RST_WR: begin
                                state_d = RST_DLY;
                                cnt_d   = RST_WAIT - 24'd1;
                            end
                            CFG_WR: begin
                                ready_d = 1'b1;
                                state_d = CFG_DLY;
                                cnt_d   = CFG_WAIT - 24'd1;
                            end
                            RD_LO: begin
                                lo_tmp_d = i2c.i2c_rdata;
                                state_d  = RD_HI;
                            end
                            default: begin
                                als_data_d  = {i2c.i2c_rdata, lo_tmp};
                                als_valid_d = 1'b1;
                                state_d     = POLL_DLY;
                                cnt_d       = POLL_CYCLES - 24'd2;
                            end
                        endcase
                    end
                end
            end
            default: begin
                // Delay states; leaving one issues the next request immediately when enabled
                if (cnt == '0 || (state == POLL_DLY && force_rd)) begin
                    req_d = en;
                    case (state)
                        RST_DLY:  state_d = CFG_WR;
                        CFG_DLY:  state_d = RD_LO;
                        POLL_DLY: state_d = RD_LO;
                        default:  state_d = RST_WR;
                    endcase
                end else begin
                    cnt_d = cnt - 24'd1;
                end
            end
        endcase

        // Command fields follow the target state so they are stable while req is high
        case (state_d)
            RST_WR: begin rw_d = 1'b0; reg_d = REG_SYS;    wdata_d = SYS_SWRST; end
            CFG_WR: begin rw_d = 1'b0; reg_d = REG_SYS;    wdata_d = CFG_MODE;  end
            RD_LO:  begin rw_d = 1'b1; reg_d = REG_ALS_LO; wdata_d = 8'h00;     end
            RD_HI:  begin rw_d = 1'b1; reg_d = REG_ALS_HI; wdata_d = 8'h00;     end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ap3216c_seq.sv
// Bench for ap3216c_seq: an I2C master model with a transaction-level
// expectation of the sensor bring-up, polling, error and reset behaviour.
module tb_ap3216c_seq;
    localparam logic [6:0] DEV  = 7'h1E;
    localparam logic [7:0] MODE = 8'h01;
    localparam int RWT = 20;
    localparam int CWT = 30;
    localparam int PCY = 40;
    localparam int EWT = 15;
    localparam int TMO = 300;
    localparam int OP_RST = 0, OP_CFG = 1, OP_LO = 2, OP_HI = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        force_rd = 1'b0;
    logic [15:0] als_data;
    logic        als_valid, err, ready;
    logic [7:0]  err_cnt;

    ap3216c_seq_if bus();

    ap3216c_seq #(
        .DEV_ADDR(DEV), .CFG_MODE(MODE),
        .RST_WAIT(24'(RWT)), .CFG_WAIT(24'(CWT)),
        .POLL_CYCLES(24'(PCY)), .ERR_WAIT(24'(EWT))
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .force_rd(force_rd), .i2c(bus),
        .als_data(als_data), .als_valid(als_valid), .err(err),
        .err_cnt(err_cnt), .ready(ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_valid = 0;
    always @(negedge clk) if (rst_n && als_valid) n_valid <= n_valid + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level expectation
    int          m_op, m_t, m_valids;
    logic [7:0]  m_lo, m_cnt;
    logic [15:0] m_als;
    logic        m_err, m_ready;

    typedef struct {
        int          lat;
        bit          nk;
        logic [7:0]  rd;
        logic [15:0] als;
        logic [7:0]  ecnt;
        bit          rdy;
        bit          vld;
    } vec_t;
    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_op = OP_RST; m_t = cyc + 1; m_lo = '0; m_als = '0;
        m_cnt = '0; m_err = 1'b0; m_ready = 1'b0;
    endtask

    // Serve one request as the I2C master and check it against the expectation
    task automatic do_op(input int lat, input bit nk, input logic [7:0] rd,
                         input int fr_off, input int en_off);
        int n = 0;
        int tr, d;
        bit ev = 1'b0;
        logic [16:0] cap;
        while (bus.i2c_req !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
        if (bus.i2c_req !== 1'b1) begin
            chk("req_timeout", 32'(n), 32'(0));
            return;
        end
        tr = cyc;
        chk("req_time", 32'(tr), 32'(m_t));
        chk("dev", 32'(bus.i2c_dev), 32'(DEV));
        chk("rw", 32'(bus.i2c_rw), 32'(m_op >= OP_LO));
        case (m_op)
            OP_RST:  begin chk("reg", 32'(bus.i2c_reg), 32'h00); chk("wdata", 32'(bus.i2c_wdata), 32'h04); end
            OP_CFG:  begin chk("reg", 32'(bus.i2c_reg), 32'h00); chk("wdata", 32'(bus.i2c_wdata), 32'(MODE)); end
            OP_LO:   chk("reg", 32'(bus.i2c_reg), 32'h0C);
            default: chk("reg", 32'(bus.i2c_reg), 32'h0D);
        endcase
        cap = {bus.i2c_rw, bus.i2c_reg, bus.i2c_wdata};
        for (int i = 0; i < lat; i++) begin
            force_rd = (i == fr_off);
            if (i == en_off) en = 1'b0;
            @(negedge clk);
        end
        force_rd = 1'b0;
        chk("req_held", 32'(bus.i2c_req), 32'(1));
        chk("cmd_stable", 32'({bus.i2c_rw, bus.i2c_reg, bus.i2c_wdata}), 32'(cap));
        bus.i2c_done = 1'b1; bus.i2c_nack = nk; bus.i2c_rdata = rd;
        @(negedge clk);
        bus.i2c_done = 1'b0; bus.i2c_nack = 1'($urandom); bus.i2c_rdata = 8'($urandom);
        d = tr + lat;
        if (nk) begin
            m_err = 1'b1;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            m_ready = 1'b0; m_op = OP_RST; m_t = d + EWT + 1;
        end else begin
            case (m_op)
                OP_RST: begin m_op = OP_CFG; m_t = d + RWT + 1; end
                OP_CFG: begin m_ready = 1'b1; m_op = OP_LO; m_t = d + CWT + 1; end
                OP_LO:  begin m_lo = rd; m_op = OP_HI; m_t = d + 2; end
                default: begin
                    m_als = {rd, m_lo}; ev = 1'b1; m_valids++;
                    m_op = OP_LO; m_t = d + PCY;
                end
            endcase
        end
        chk("req_drop", 32'(bus.i2c_req), 32'(0));
        chk("als_data", 32'(als_data), 32'(m_als));
        chk("als_valid", 32'(als_valid), 32'(ev));
        chk("err", 32'(err), 32'(m_err));
        chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
        chk("ready", 32'(ready), 32'(m_ready));
    endtask

    task automatic chk_reset_vals();
        chk("rst_req", 32'(bus.i2c_req), 32'(0));
        chk("rst_rw", 32'(bus.i2c_rw), 32'(0));
        chk("rst_reg", 32'(bus.i2c_reg), 32'h00);
        chk("rst_wdata", 32'(bus.i2c_wdata), 32'h04);
        chk("rst_als", 32'(als_data), 32'(0));
        chk("rst_valid", 32'(als_valid), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_err_cnt", 32'(err_cnt), 32'(0));
        chk("rst_ready", 32'(ready), 32'(0));
    endtask

    initial begin
        int hi_cnt;
        int n;
        tbl[0]  = '{4, 0, 8'h00, 16'h0000, 8'd0, 0, 0};
        tbl[1]  = '{4, 0, 8'h00, 16'h0000, 8'd0, 1, 0};
        tbl[2]  = '{4, 0, 8'h34, 16'h0000, 8'd0, 1, 0};
        tbl[3]  = '{4, 0, 8'h12, 16'h1234, 8'd0, 1, 1};
        tbl[4]  = '{2, 0, 8'h99, 16'h1234, 8'd0, 1, 0};
        tbl[5]  = '{4, 1, 8'h56, 16'h1234, 8'd1, 0, 0};
        tbl[6]  = '{1, 0, 8'h00, 16'h1234, 8'd1, 0, 0};
        tbl[7]  = '{0, 0, 8'h00, 16'h1234, 8'd1, 1, 0};
        tbl[8]  = '{0, 0, 8'hCD, 16'h1234, 8'd1, 1, 0};
        tbl[9]  = '{0, 0, 8'hAB, 16'hABCD, 8'd1, 1, 1};
        tbl[10] = '{3, 1, 8'hEE, 16'hABCD, 8'd2, 0, 0};
        tbl[11] = '{2, 1, 8'h00, 16'hABCD, 8'd3, 0, 0};
        tbl[12] = '{1, 0, 8'h00, 16'hABCD, 8'd3, 0, 0};
        tbl[13] = '{5, 1, 8'h00, 16'hABCD, 8'd4, 0, 0};
        tbl[14] = '{0, 0, 8'h00, 16'hABCD, 8'd4, 0, 0};
        tbl[15] = '{2, 0, 8'h00, 16'hABCD, 8'd4, 1, 0};
        tbl[16] = '{1, 0, 8'h00, 16'hABCD, 8'd4, 1, 0};
        tbl[17] = '{3, 0, 8'hFF, 16'hFF00, 8'd4, 1, 1};

        bus.i2c_done = 1'b0; bus.i2c_nack = 1'b0; bus.i2c_rdata = 8'h00;
        m_valids = 0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        chk("rst_dev", 32'(bus.i2c_dev), 32'(DEV));
        rst_n = 1'b1;
        model_reset();

        // Bring-up, polling and NACK recovery vectors
        for (int i = 0; i < 18; i++) begin
            do_op(tbl[i].lat, tbl[i].nk, tbl[i].rd, -1, -1);
            chk("tbl_als", 32'(als_data), 32'(tbl[i].als));
            chk("tbl_err_cnt", 32'(err_cnt), 32'(tbl[i].ecnt));
            chk("tbl_ready", 32'(ready), 32'(tbl[i].rdy));
            chk("tbl_valid", 32'(als_valid), 32'(tbl[i].vld));
            chk("tbl_err", 32'(err), 32'(tbl[i].ecnt != 8'd0));
        end

        // force_rd ten cycles into POLL_DLY, then ignored during RD_HI
        repeat (9) @(negedge clk);
        force_rd = 1'b1;
        m_t = cyc + 1;
        @(negedge clk);
        force_rd = 1'b0;
        do_op(4, 0, 8'h78, -1, -1);
        do_op(4, 0, 8'h56, 2, -1);
        chk("force_als", 32'(als_data), 32'h5678);
        do_op(1, 0, 8'h11, -1, -1);
        do_op(1, 0, 8'h22, -1, -1);

        // en dropped during RD_LO withholds RD_HI until en returns
        do_op(4, 0, 8'hBE, -1, 1);
        hi_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.i2c_req) hi_cnt++;
        end
        chk("req_withheld", 32'(hi_cnt), 32'(0));
        en = 1'b1;
        m_t = cyc + 1;
        do_op(2, 0, 8'hEF, -1, -1);
        chk("en_als", 32'(als_data), 32'hEFBE);

        // Randomised traffic
        for (int i = 0; i < 60; i++)
            do_op(int'($urandom_range(0, 5)), ($urandom_range(0, 7) == 0), 8'($urandom), -1, -1);

        // Error counter saturation
        for (int i = 0; i < 300; i++)
            do_op(0, 1, 8'h00, -1, -1);
        chk("err_cnt_sat", 32'(err_cnt), 32'd255);

        // Reset asserted in the middle of a request
        n = 0;
        while (bus.i2c_req !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
        chk("req_before_rst", 32'(bus.i2c_req), 32'(1));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals();
        @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;
        model_reset();
        do_op(3, 0, 8'h00, -1, -1);
        // Stray done while no request is outstanding
        bus.i2c_done = 1'b1; bus.i2c_nack = 1'b1;
        @(negedge clk);
        bus.i2c_done = 1'b0; bus.i2c_nack = 1'b0;
        do_op(2, 0, 8'h00, -1, -1);
        chk("stray_err_cnt", 32'(err_cnt), 32'(0));
        do_op(1, 0, 8'h5A, -1, -1);
        do_op(1, 0, 8'hA5, -1, -1);
        chk("post_rst_als", 32'(als_data), 32'hA55A);
        @(negedge clk);
        chk("valid_pulses", 32'(n_valid), 32'(m_valids));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
